// File: rtl/neuron_pkg.sv
// Shared fixed-point format, saturation helper and detector state encoding
// for the neuron / synapse blocks.
package neuron_pkg;

    localparam int W    = 21;
    localparam int FRAC = 9;

    typedef logic signed [W-1:0] fx_t;
    typedef logic signed [W+1:0] fx_wide_t;

    localparam fx_t FX_MAX        = fx_t'({1'b0, {(W-1){1'b1}}});
    localparam fx_t FX_MIN        = fx_t'({1'b1, {(W-1){1'b0}}});
    localparam fx_t VPEAK_DEFAULT = fx_t'(30 << FRAC);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        REFRACT = 2'd1,
        REARM   = 2'd2
    } det_state_t;

    // Clamp a W+2 bit intermediate back into the W-bit range.
    function automatic fx_t sat_fx(input fx_wide_t x);
        fx_t r;
        if (x[W+1:W-1] == 3'b000 || x[W+1:W-1] == 3'b111) begin
            r = fx_t'(x[W-1:0]);
        end else if (x[W+1]) begin
            r = FX_MIN;
        end else begin
            r = FX_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_detect.sv
// Threshold-crossing spike detector: ARMED/REFRACT/REARM FSM, refractory
// counter, registered spike pulse and saturating spike counter.
module spike_detect
    import neuron_pkg::*;
#(
    parameter fx_t VPEAK  = VPEAK_DEFAULT,
    parameter int  REFRAC = 2
) (
    input  logic        clk,
    input  logic        set_n,
    input  logic        en,
    input  fx_t         v_pre,
    output logic        detect,
    output logic        spike_out,
    output logic [15:0] spike_cnt,
    output det_state_t  state
);

    localparam int CW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

    det_state_t    state_nxt;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nxt;
    logic          above;

    assign above = (v_pre >= VPEAK);

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        detect    = 1'b0;
        if (en) begin
            case (state)
                ARMED: begin
                    if (above) begin
                        state_nxt = REFRACT;
                        rcnt_nxt  = CW'(REFRAC);
                        detect    = 1'b1;
                    end
                end
                REFRACT: begin
                    // A level still above threshold when the counter runs out is
                    // the same spike; wait in REARM for it to drop.
                    if (rcnt == '0) begin
                        state_nxt = above ? REARM : ARMED;
                    end else begin
                        rcnt_nxt = rcnt - CW'(1);
                    end
                end
                REARM: begin
                    if (!above) begin
                        state_nxt = ARMED;
                    end
                end
                default: state_nxt = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state     <= ARMED;
            rcnt      <= '0;
            spike_out <= 1'b0;
            spike_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            rcnt      <= rcnt_nxt;
            spike_out <= detect;
            if (detect && spike_cnt != 16'hFFFF) begin
                spike_cnt <= spike_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/spike_synapse.sv
// Post-synaptic current generator: detected spikes are delayed, weighted and
// accumulated into an exponentially decaying current. Optional axonal delay
// line is built when SYN_DELAY_EN is defined; otherwise the delay is one step.
module spike_synapse
    import neuron_pkg::*;
#(
    parameter fx_t VPEAK     = VPEAK_DEFAULT,
    parameter int  TAU_SHIFT = 3,
    parameter int  REFRAC    = 2,
    parameter int  DELAY     = 4
) (
    input  logic        clk,
    input  logic        set_n,
    input  logic        en,
    input  fx_t         v_pre,
    input  fx_t         weight,
    input  fx_t         i_bias,
    output fx_t         i_syn,
    output logic        spike_out,
    output logic [15:0] spike_cnt,
    output det_state_t  det_state
);

    // en is a step strobe, not a handshake: every cycle with en=1 is one
    // update step, and with en=0 all state (including the delay line) holds.

`ifdef SYN_DELAY_EN
    localparam int D = DELAY;
`else
    // Without the delay line the registered detection flag lands one step later.
    localparam int D = 1 + 0 * DELAY;
`endif

    logic     detect;
    logic     applied;
    logic [D-1:0] dline;

    fx_t      i_acc;
    fx_t      dec;
    fx_t      i_acc_nxt;
    fx_wide_t sum_acc;
    fx_wide_t sum_out;

    spike_detect #(
        .VPEAK  (VPEAK),
        .REFRAC (REFRAC)
    ) u_detect (
        .clk       (clk),
        .set_n     (set_n),
        .en        (en),
        .v_pre     (v_pre),
        .detect    (detect),
        .spike_out (spike_out),
        .spike_cnt (spike_cnt),
        .state     (det_state)
    );

    // Oldest flag applies this step while the new detection shifts in, so a
    // simultaneous detect and apply never collide.
    assign applied = dline[D-1];

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            dline <= '0;
        end else if (en) begin
            dline <= D'({dline, detect});
        end
    end

    always_comb begin
        dec = i_acc >>> TAU_SHIFT;
        // Small magnitudes would otherwise stall; force a unit step toward zero.
        if (dec == '0 && i_acc != '0) begin
            dec = i_acc[W-1] ? fx_t'(-1) : fx_t'(1);
        end
        sum_acc   = fx_wide_t'(i_acc) - fx_wide_t'(dec)
                  + (applied ? fx_wide_t'(weight) : fx_wide_t'(0));
        i_acc_nxt = sat_fx(sum_acc);
        sum_out   = fx_wide_t'(i_acc_nxt) + fx_wide_t'(i_bias);
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            i_acc <= '0;
            i_syn <= '0;
        end else if (en) begin
            i_acc <= i_acc_nxt;
            i_syn <= sat_fx(sum_out);
        end
    end

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse: expected i_syn/spike_cnt values are queued
// with the cycle they are due, and monitors compare them as outputs appear.
`timescale 1ns/1ps
module tb_spike_synapse;
    import neuron_pkg::*;

    localparam int W_TB = 21;
`ifdef SYN_DELAY_EN
    localparam int D_TB = 4;
`else
    localparam int D_TB = 1;
`endif
    localparam fx_t LO   = fx_t'(-13312);
    localparam fx_t HI   = fx_t'(15360);
    localparam fx_t PLAT = fx_t'(20000);

    logic        clk = 1'b0;
    logic        set_n;
    logic        en;
    fx_t         v_pre;
    fx_t         weight;
    fx_t         i_bias;
    fx_t         i_syn;
    logic        spike_out;
    logic [15:0] spike_cnt;
    det_state_t  det_state;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int sc     = 0;
    int kc;

    logic [W_TB-1:0] exp_q[$];
    int              exp_cyc_q[$];
    int              exp_cnt_q[$];
    logic [15:0]     spk_q[$];

    int              m_c;
    int              m_ec;
    logic [W_TB-1:0] m_e;
    logic [15:0]     m_s;

    spike_synapse u_dut (
        .clk       (clk),
        .set_n     (set_n),
        .en        (en),
        .v_pre     (v_pre),
        .weight    (weight),
        .i_bias    (i_bias),
        .i_syn     (i_syn),
        .spike_out (spike_out),
        .spike_cnt (spike_cnt),
        .det_state (det_state)
    );

    // Clock / cycle counter: cyc counts rising edges seen so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cyc %0d reached time limit", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: current and count checks due this cycle, plus spike pulses.
    always @(negedge clk) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            m_c  = exp_cyc_q.pop_front();
            m_e  = exp_q.pop_front();
            m_ec = exp_cnt_q.pop_front();
            checks++;
            if (m_c != cyc || i_syn !== m_e) begin
                errors++;
                $display("FAIL i_syn cyc %0d (due %0d): got %0d want %0d",
                         cyc, m_c, i_syn, $signed(m_e));
            end
            if (m_ec >= 0) begin
                checks++;
                if (spike_cnt !== 16'(m_ec)) begin
                    errors++;
                    $display("FAIL spike_cnt cyc %0d: got %0d want %0d", cyc, spike_cnt, m_ec);
                end
            end
        end
        if (spike_out !== 1'b0) begin
            checks++;
            if (spk_q.size() == 0) begin
                errors++;
                $display("FAIL spike_pulse cyc %0d: got spike_out=%b want 0", cyc, spike_out);
            end else begin
                m_s = spk_q.pop_front();
                if (spike_cnt !== m_s) begin
                    errors++;
                    $display("FAIL spike_pulse_cnt cyc %0d: got %0d want %0d", cyc, spike_cnt, m_s);
                end
            end
        end
    end

    // Driver tasks: inputs change on the falling edge, take effect on the next rise.
    task automatic step(input logic e, input fx_t v);
        en    = e;
        v_pre = v;
        @(negedge clk);
    endtask

    task automatic push_exp(input int c, input int val, input int cnt);
        exp_cyc_q.push_back(c);
        exp_q.push_back(W_TB'(val));
        exp_cnt_q.push_back(cnt);
    endtask

    task automatic stepc(input logic e, input fx_t v, input int val, input int cnt);
        push_exp(cyc + 1, val, cnt);
        step(e, v);
    endtask

    task automatic expect_spike();
        sc++;
        spk_q.push_back(16'(sc));
    endtask

    task automatic check_now(input int got, input int want, input string name);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    initial begin
        set_n  = 1'b0;
        en     = 1'b0;
        v_pre  = LO;
        weight = '0;
        i_bias = '0;

        // Reset held with en toggling and v_pre crossing threshold.
        for (int i = 0; i < 6; i++) begin
            stepc(i[0], (i % 2 == 1) ? HI : LO, 0, 0);
        end
        set_n = 1'b1;
        stepc(1'b1, LO, 0, 0);
        check_now(int'(det_state), int'(ARMED), "state_after_reset");

        // Single spike: weight lands D steps after detection, then decays.
        weight = fx_t'(5120);
        stepc(1'b1, LO, 0, 0);
        expect_spike();
        stepc(1'b1, HI, 0, -1);
        for (int j = 1; j < D_TB; j++) stepc(1'b1, LO, 0, -1);
        stepc(1'b1, LO, 5120, 1);
        stepc(1'b1, LO, 4480, -1);
        stepc(1'b1, LO, 3920, -1);
        stepc(1'b1, LO, 3430, -1);
        stepc(1'b1, LO, 3002, -1);
        for (int j = 0; j < 150; j++) step(1'b1, LO);
        stepc(1'b1, LO, 0, 1);

        // Plateau above threshold counts once; bias passes straight through.
        weight = '0;
        i_bias = fx_t'(100);
        stepc(1'b1, LO, 100, -1);
        expect_spike();
        for (int j = 0; j < 10; j++) step(1'b1, PLAT);
        check_now(int'(det_state), int'(REARM), "state_plateau");
        stepc(1'b1, LO, 100, 2);
        for (int j = 0; j < 4; j++) step(1'b1, LO);
        expect_spike();
        step(1'b1, HI);
        for (int j = 0; j < 4; j++) step(1'b1, LO);
        stepc(1'b1, LO, 100, 3);
        i_bias = '0;
        stepc(1'b1, LO, 0, -1);

        // Positive saturation.
        weight = fx_t'(1048575);
        for (int n = 0; n < 5; n++) begin
            expect_spike();
            kc = cyc + 1;
            push_exp(kc + D_TB, 1048575, -1);
            push_exp(kc + D_TB + 1, 917504, -1);
            step(1'b1, HI);
            for (int j = 0; j < 4; j++) step(1'b1, LO);
        end
        weight = '0;
        for (int j = 0; j < 200; j++) step(1'b1, LO);
        stepc(1'b1, LO, 0, sc);

        // Negative saturation.
        weight = fx_t'(-1048576);
        for (int n = 0; n < 3; n++) begin
            expect_spike();
            kc = cyc + 1;
            push_exp(kc + D_TB, -1048576, -1);
            push_exp(kc + D_TB + 1, -917504, -1);
            step(1'b1, HI);
            for (int j = 0; j < 4; j++) step(1'b1, LO);
        end
        weight = '0;
        for (int j = 0; j < 200; j++) step(1'b1, LO);
        stepc(1'b1, LO, 0, sc);

        // en gating with a spike pending in the delay path.
        weight = fx_t'(5120);
        expect_spike();
        stepc(1'b1, HI, 0, -1);
        for (int j = 1; j < D_TB; j++) stepc(1'b1, LO, 0, -1);
        stepc(1'b1, LO, 5120, -1);
        stepc(1'b1, LO, 4480, -1);
        stepc(1'b1, LO, 3920, -1);
        stepc(1'b1, LO, 3430, -1);
        expect_spike();
        stepc(1'b1, HI, 3002, -1);
        for (int j = 0; j < 20; j++) stepc(1'b0, (j % 2 == 1) ? HI : LO, 3002, -1);
`ifdef SYN_DELAY_EN
        stepc(1'b1, LO, 2627, -1);
        stepc(1'b1, LO, 2299, -1);
        stepc(1'b1, LO, 2012, -1);
        stepc(1'b1, LO, 6881, sc);
`else
        stepc(1'b1, LO, 7747, sc);
`endif
        for (int j = 0; j < 150; j++) step(1'b1, LO);
        stepc(1'b1, LO, 0, -1);

        // Reset two steps after detection discards the pending spike.
        expect_spike();
        stepc(1'b1, HI, 0, -1);
`ifdef SYN_DELAY_EN
        stepc(1'b1, LO, 0, -1);
        stepc(1'b1, LO, 0, -1);
`else
        stepc(1'b1, LO, 5120, -1);
        stepc(1'b1, LO, 4480, -1);
`endif
        set_n = 1'b0;
        #1;
        check_now(int'(i_syn), 0, "i_syn_async_reset");
        check_now(int'(spike_cnt), 0, "spike_cnt_async_reset");
        stepc(1'b1, LO, 0, 0);
        set_n = 1'b1;
        sc    = 0;
        for (int j = 0; j < 8; j++) stepc(1'b1, LO, 0, 0);

        for (int j = 0; j < 3; j++) step(1'b0, LO);
        check_now(exp_cyc_q.size(), 0, "pending_checks");
        check_now(spk_q.size(), 0, "missing_spikes");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
